// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, default frame geometry and the parity helper used by TX and RX.
// With UART_TX_PARITY_EN defined the TX state set gains a PARITY state.
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;
    // Zero-extended upper bits do not disturb the XOR, so narrow words pass in directly.
    function automatic logic calc_parity(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer; start bit, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits.
// Ports: clk/rst (async active-high), tx_send + data_in request, baud_en_tx bit tick,
//        tx_data_out serial line (idles high), tx_active frame-in-flight flag, tx_done end-of-frame pulse.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (adds parameter PARITY_ODD).
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int STOP_BITS = UART_STOP_BITS
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_send,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 baud_en_tx,
    output logic                 tx_data_out,
    output logic                 tx_active,
    output logic                 tx_done
);
    tx_state_t            r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [3:0]           r_bit_cnt, w_bit_nxt;
    logic [1:0]           r_stop_cnt, w_stop_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_active, w_active_nxt;
    logic                 r_done, w_done_nxt;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity, w_parity_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_tx       <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_tx       <= w_tx_nxt;
            r_active   <= w_active_nxt;
            r_done     <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bit_nxt    = r_bit_cnt;
        w_stop_nxt   = r_stop_cnt;
        w_tx_nxt     = r_tx;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (tx_send) begin
                    w_state_nxt  = ARM;
                    w_shift_nxt  = data_in;
                    w_bit_nxt    = '0;
                    w_stop_nxt   = '0;
                    w_active_nxt = 1'b1;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = calc_parity(8'(data_in), PARITY_ODD);
`endif
                end
            end
            // Waiting for a fresh tick so the start bit lasts a full baud period.
            ARM: if (baud_en_tx) begin
                w_state_nxt = START;
                w_tx_nxt    = 1'b0;
            end
            START: if (baud_en_tx) begin
                w_state_nxt = DATA;
                w_tx_nxt    = r_shift[0];
                w_shift_nxt = r_shift >> 1;
                w_bit_nxt   = 4'd1;
            end
            // r_bit_cnt counts data bits already placed on the line.
            DATA: if (baud_en_tx) begin
                if (r_bit_cnt == 4'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = PARITY;
                    w_tx_nxt    = r_parity;
`else
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
`endif
                end else begin
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = r_bit_cnt + 4'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_en_tx) begin
                w_state_nxt = STOP;
                w_tx_nxt    = 1'b1;
            end
`endif
            STOP: if (baud_en_tx) begin
                if (r_stop_cnt == 2'(STOP_BITS - 1)) begin
                    w_state_nxt  = IDLE;
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_stop_nxt = r_stop_cnt + 2'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign tx_data_out = r_tx;
    assign tx_active   = r_active;
    assign tx_done     = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx against a frame-list reference model.
module tb_uart_tx;
    localparam int DB = 8;
    localparam int SB = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_send = 1'b0;
    logic [DB-1:0] data_in = '0;
    logic          baud_en_tx = 1'b0;
    logic          tx_data_out;
    logic          tx_active;
    logic          tx_done;

    int n_vec = 0;
    int n_err = 0;

    uart_tx #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_send    (tx_send),
        .data_in    (data_in),
        .baud_en_tx (baud_en_tx),
        .tx_data_out(tx_data_out),
        .tx_active  (tx_active),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line levels after each successive tick, following the start edge.
    function automatic void build_frame(input logic [DB-1:0] d, output bit q[$]);
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < DB; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        q.push_back(^d);
`endif
        for (int i = 0; i < SB; i++) q.push_back(1'b1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        baud_en_tx = 1'b1;
        step();
        baud_en_tx = 1'b0;
    endtask

    task automatic send(input logic [DB-1:0] d, input bit with_tick);
        data_in    = d;
        tx_send    = 1'b1;
        baud_en_tx = with_tick;
        step();
        tx_send    = 1'b0;
        baud_en_tx = 1'b0;
        data_in    = DB'($urandom);
        chk("accept_active", tx_active, 1);
        chk("accept_line", tx_data_out, 1);
        chk("accept_done", tx_done, 0);
    endtask

    // Walks one accepted frame to completion; busy_at>0 fires a rejected send alongside that tick.
    task automatic run_frame(input logic [DB-1:0] d, input int busy_at, input bit b2b);
        bit q[$];
        build_frame(d, q);
        for (int k = 1; k <= q.size() + 1; k++) begin
            if (k == busy_at) begin
                tx_send = 1'b1;
                data_in = 8'h55;
            end
            tick();
            tx_send = 1'b0;
            if (k <= q.size()) begin
                chk("frame_line", tx_data_out, q[k-1]);
                chk("frame_active", tx_active, 1);
                chk("frame_done", tx_done, 0);
                repeat ($urandom_range(0, 3)) begin
                    step();
                    chk("hold_line", tx_data_out, q[k-1]);
                end
            end else begin
                chk("end_done", tx_done, 1);
                chk("end_active", tx_active, 0);
                chk("end_line", tx_data_out, 1);
            end
        end
        if (!b2b) begin
            step();
            chk("done_pulse", tx_done, 0);
        end
    endtask

    task automatic idle_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, {5'd0, tx_data_out, tx_active, tx_done}, 8'b100);
            step();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {5'd0, tx_data_out, tx_active, tx_done}, 8'b100);
        rst = 1'b0;
        step();
        idle_ticks(3, "idle");

        send(8'hAA, 1'b0);
        run_frame(8'hAA, 4, 1'b0);
        idle_ticks(12, "no_second_frame");

        send(8'hF0, 1'b0);
        run_frame(8'hF0, 0, 1'b0);

        send(8'h07, 1'b1);
        run_frame(8'h07, 0, 1'b1);
        send(8'h3C, 1'b0);
        run_frame(8'h3C, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [DB-1:0] d;
            d = DB'($urandom);
            send(d, 1'($urandom_range(0, 1)));
            run_frame(d, int'($urandom_range(0, 11)), 1'b0);
            repeat ($urandom_range(0, 4)) step();
        end

        send(8'hC3, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_line", tx_data_out, 1);
        chk("rst_mid_active", tx_active, 0);
        chk("rst_mid_done", tx_done, 0);
        step();
        rst = 1'b0;
        idle_ticks(12, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
